cnn_conv2d_stream: RTL and testbench
====================================

# cnn_conv2d_stream

Sequential, parameterised 2-D convolution engine for the CNN accelerator. It accepts a K×K kernel and an IMG_H×IMG_W image over one valid/ready input stream. It then computes every valid-padding output position with a single time-multiplexed MAC, one product per cycle. Results stream out in row-major order over a valid/ready output port. It generalises the fixed 4×4 / 3×3 combinational convolver and adds streaming, back-pressure and optional saturation.

## Interface
- DATA_W, 8, unsigned pixel and kernel word width
- IMG_W, 4, image width in pixels (≥ K)
- IMG_H, 4, image height in pixels (≥ K)
- K, 3, kernel side length (≥ 1)
- OUT_W, 8, output word width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  engine accepts an input word
- in_data  in  DATA_W  kernel word or pixel, row-major
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  OUT_W  convolution result
- out_last  out  1  marks the final result of the frame
- busy  out  1  high in every state except LOAD_KER with zero words received

## Operation
- Internal widths:
  - ACC_W = 2·DATA_W + clog2(K·K), so the accumulator never overflows.
  - OH = IMG_H−K+1; OW = IMG_W−K+1.
- Frame format: K·K kernel words (row-major, ker[r][c]), then IMG_H·IMG_W pixels (row-major). A word transfers on any edge where in_valid && in_ready.
- FSM states:
  - LOAD_KER: in_ready=1. Store words into kernel regs. After word K·K−1 → LOAD_IMG.
  - LOAD_IMG: in_ready=1. Store pixels into the image buffer. After pixel IMG_H·IMG_W−1 → COMPUTE, with output position (oy,ox)=(0,0), tap index 0, acc cleared.
  - COMPUTE: in_ready=0. Each cycle: acc += img[oy+r][ox+c]·ker[r][c], with tap (r,c) walking row-major. After tap K·K−1 → OUTPUT.
  - OUTPUT: out_valid=1 and out_data=f(acc). out_last=1 iff (oy,ox)=(OH−1,OW−1). On out_ready:
    - if last → LOAD_KER;
    - otherwise advance ox (wrapping to 0 and incrementing oy), clear acc, → COMPUTE.
- While out_valid=1 without out_ready, out_data and out_last hold stable.
- in_data is ignored whenever in_ready=0.
- Reset (async, any state, including mid-frame): state=LOAD_KER, all counters=0, acc=0.
  - Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
  - Kernel and image buffers need not be cleared.

## Timing
- Input throughput: 1 word/cycle with in_valid held high. The frame input takes K·K + IMG_H·IMG_W accepted words.
- First result: out_valid rises K·K edges after the edge that accepts the last pixel (9 edges at defaults).
- Each later result: K·K edges after the previous out_valid && out_ready edge. There are no bubbles beyond that.
- The last-result handshake edge moves the FSM to LOAD_KER. in_ready=1 in the following cycle.
- The FSM registers, out_valid and in_ready are all registered or pure state decodes. There is no combinational path from out_ready or in_valid to any output.

## Configuration
- CONV_SAT_EN defined: out_data = (acc > 2^OUT_W−1) ? 2^OUT_W−1 : acc[OUT_W−1:0].
- CONV_SAT_EN undefined: out_data = acc[OUT_W−1:0], i.e. modulo-2^OUT_W truncation, matching the legacy convolver.

## Structure
- Package cnn_pkg holds:
  - the state enum (LOAD_KER, LOAD_IMG, COMPUTE, OUTPUT);
  - a clog2 helper function;
  - the ACC_W derivation as a function of DATA_W and K.
- Sub-module cnn_mac_unit (params DATA_W, ACC_W):
  - inputs clk, rst, clr, en, a, b; output acc;
  - registered acc ← clr ? 0 : en ? acc+a·b : acc.
- Saturation/truncation, the image and kernel buffers, and the FSM stay in the top module.

## Test plan
- Defaults, no macro; kernel all 1; pixels all 1 → four results of 9, out_last only on the 4th.
- Kernel center=1, others 0; pixels 0..15 row-major → outputs 5, 6, 9, 10 in order.
- Kernel and pixels all 255 → 9 without CONV_SAT_EN (585225 mod 256), 255 with it.
- out_ready low for 5 cycles on result 2 → out_valid, out_data=6 and out_last=0 stable throughout. Result 3 arrives 9 edges after the accepting edge.
- Assert rst during COMPUTE of result 3 → immediately out_valid=0, in_ready=1, busy=0. A full new frame afterwards produces correct results.
- in_valid toggled 1-0-1 every cycle during load → the same outputs as the contiguous load; the first out_valid occurs 9 edges after the last pixel handshake.

Source files
------------

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
//   Shared definitions for the streaming 2-D convolution engine:
//     state_t    : engine FSM states
//     clog2      : ceil(log2(v)), 0 for v <= 1
//     idx_width  : bits needed to index 0..n-1 (at least 1)
//     acc_width  : accumulator width that cannot overflow over K*K products
// -----------------------------------------------------------------------------
package cnn_pkg;

    typedef enum logic [1:0] {
        LOAD_KER,
        LOAD_IMG,
        COMPUTE,
        OUTPUT
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned res;
        int unsigned pw;
        res = 0;
        pw  = 1;
        while (pw < v) begin
            pw  = pw << 1;
            res = res + 1;
        end
        return res;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (clog2(n) == 0) ? 1 : clog2(n);
    endfunction

    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned k);
        return 2 * data_w + clog2(k * k);
    endfunction

endpackage

// File: rtl/cnn_mac_unit.sv
// -----------------------------------------------------------------------------
// cnn_mac_unit
//   Single multiply-accumulate register.
//   acc <= clr ? 0 : en ? acc + a*b : acc
// Ports:
//   clk, rst : clock, asynchronous active-high reset (acc -> 0)
//   clr      : synchronous clear (wins over en)
//   en       : accumulate a*b this cycle
//   a, b     : unsigned DATA_W operands
//   acc      : ACC_W accumulator
// -----------------------------------------------------------------------------
module cnn_mac_unit #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(a) * ACC_W'(b);
        end
    end

endmodule

// File: rtl/cnn_conv2d_stream.sv
// -----------------------------------------------------------------------------
// cnn_conv2d_stream
//   Streaming valid-padding 2-D convolution with one time-multiplexed MAC.
//   Frame in: K*K kernel words then IMG_H*IMG_W pixels, row-major.
//   Results out row-major, one per K*K compute cycles.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : input word handshake, in_data = kernel word or pixel
//   out_valid/out_ready: result handshake, out_data = result,
//                        out_last flags the final result of the frame
//   busy               : low only when idle in LOAD_KER with no words taken
// Build option:
//   CONV_SAT_EN : saturate out_data at 2^OUT_W-1 instead of truncating
// -----------------------------------------------------------------------------
module cnn_conv2d_stream
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 4,
    parameter int unsigned IMG_H  = 4,
    parameter int unsigned K      = 3,
    parameter int unsigned OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned ACC_W = acc_width(DATA_W, K);
    localparam int unsigned OH    = IMG_H - K + 1;
    localparam int unsigned OW    = IMG_W - K + 1;
    localparam int unsigned KK    = K * K;
    localparam int unsigned NPIX  = IMG_H * IMG_W;
    localparam int unsigned CNT_W = idx_width((NPIX > KK) ? NPIX : KK);
    localparam int unsigned TAP_W = idx_width(K);
    localparam int unsigned OY_W  = idx_width(OH);
    localparam int unsigned OX_W  = idx_width(OW);
    localparam int unsigned PIX_W = idx_width(NPIX);
    localparam int unsigned KER_W = idx_width(KK);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [TAP_W-1:0]   r;
    logic [TAP_W-1:0]   c;
    logic [OY_W-1:0]    oy;
    logic [OX_W-1:0]    ox;

    logic [DATA_W-1:0]  ker_buf [KK];
    logic [DATA_W-1:0]  img_buf [NPIX];

    logic [PIX_W-1:0]   pix_idx;
    logic [KER_W-1:0]   ker_idx;
    logic               mac_clr;
    logic               mac_en;
    logic [ACC_W-1:0]   acc;
    logic               last_pix;

    assign last_pix = (state == LOAD_IMG) && in_valid && (cnt == CNT_W'(NPIX - 1));
    assign busy     = !((state == LOAD_KER) && (cnt == '0));

    always_comb begin
        pix_idx = PIX_W'((32'(oy) + 32'(r)) * IMG_W + 32'(ox) + 32'(c));
        ker_idx = KER_W'(32'(r) * K + 32'(c));
    end

    // Buffers are plain storage; no reset needed since every location is
    // rewritten by each frame before it is read.
    always_ff @(posedge clk) begin
        if (state == LOAD_KER && in_valid) begin
            ker_buf[KER_W'(cnt)] <= in_data;
        end
        if (state == LOAD_IMG && in_valid) begin
            img_buf[PIX_W'(cnt)] <= in_data;
        end
    end

    // Accumulator is cleared on entry to every COMPUTE phase.
    assign mac_clr = last_pix || ((state == OUTPUT) && out_ready);
    assign mac_en  = (state == COMPUTE);

    cnn_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (img_buf[pix_idx]),
        .b   (ker_buf[ker_idx]),
        .acc (acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD_KER;
            cnt       <= '0;
            r         <= '0;
            c         <= '0;
            oy        <= '0;
            ox        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                LOAD_KER: begin
                    if (in_valid) begin
                        if (cnt == CNT_W'(KK - 1)) begin
                            cnt   <= '0;
                            state <= LOAD_IMG;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_IMG: begin
                    if (in_valid) begin
                        if (cnt == CNT_W'(NPIX - 1)) begin
                            cnt      <= '0;
                            r        <= '0;
                            c        <= '0;
                            oy       <= '0;
                            ox       <= '0;
                            in_ready <= 1'b0;
                            state    <= COMPUTE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (c == TAP_W'(K - 1)) begin
                        c <= '0;
                        if (r == TAP_W'(K - 1)) begin
                            r         <= '0;
                            out_valid <= 1'b1;
                            out_last  <= (oy == OY_W'(OH - 1)) && (ox == OX_W'(OW - 1));
                            state     <= OUTPUT;
                        end else begin
                            r <= r + 1'b1;
                        end
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            oy       <= '0;
                            ox       <= '0;
                            in_ready <= 1'b1;
                            state    <= LOAD_KER;
                        end else begin
                            if (ox == OX_W'(OW - 1)) begin
                                ox <= '0;
                                oy <= oy + 1'b1;
                            end else begin
                                ox <= ox + 1'b1;
                            end
                            state <= COMPUTE;
                        end
                    end
                end
                default: state <= LOAD_KER;
            endcase
        end
    end

`ifdef CONV_SAT_EN
    localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);
    always_comb out_data = (acc > OUT_MAX) ? '1 : acc[OUT_W-1:0];
`else
    always_comb out_data = acc[OUT_W-1:0];
`endif

endmodule

// File: tb/tb_cnn_conv2d_stream.sv
// -----------------------------------------------------------------------------
// tb_cnn_conv2d_stream
//   Scoreboard bench for cnn_conv2d_stream at default parameters.
// -----------------------------------------------------------------------------
module tb_cnn_conv2d_stream;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         ref_cyc = 0;
    int         n_acc = 0;
    logic       prev_valid = 1'b0;

    logic [7:0] ker_v [9];
    logic [7:0] pix_v [16];

    cnn_conv2d_stream #(
        .DATA_W (8),
        .IMG_W  (4),
        .IMG_H  (4),
        .K      (3),
        .OUT_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Monitor: latency of every result and scoreboard compare on handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                chk("result_latency", cyc - ref_cyc, 9);
            end
            prev_valid = out_valid;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got data=%0d last=%0d, want none",
                             out_data, out_last);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (out_data !== e.data || out_last !== e.last) begin
                        errors++;
                        $display("FAIL result: got data=%0d last=%0d, want data=%0d last=%0d",
                                 out_data, out_last, e.data, e.last);
                    end
                end
                n_acc++;
                ref_cyc = cyc + 1;
            end
        end
    end

    task automatic push4(input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
        sb.push_back('{d0, 1'b0});
        sb.push_back('{d1, 1'b0});
        sb.push_back('{d2, 1'b0});
        sb.push_back('{d3, 1'b1});
    endtask

    task automatic send_word(input logic [7:0] w, input bit is_last, input bit tog);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
        if (is_last) ref_cyc = cyc;
        in_valid = 1'b0;
        if (tog) begin
            in_data = 8'hA5;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input bit tog);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL in_ready_timeout: got in_ready=0, want 1");
        end
        for (int i = 0; i < 9; i++) send_word(ker_v[i], 1'b0, tog);
        for (int i = 0; i < 16; i++) send_word(pix_v[i], i == 15, tog);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (n_acc < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("accept_count", n_acc, target);
    endtask

    task automatic post_frame();
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_out_valid", out_valid, 0);
    endtask

    task automatic fill_ones();
        for (int i = 0; i < 9; i++) ker_v[i] = 8'd1;
        for (int i = 0; i < 16; i++) pix_v[i] = 8'd1;
    endtask

    task automatic fill_center_ramp();
        for (int i = 0; i < 9; i++) ker_v[i] = (i == 4) ? 8'd1 : 8'd0;
        for (int i = 0; i < 16; i++) pix_v[i] = 8'(i);
    endtask

    initial begin
        int n;
        int base;
        logic [7:0] sat_exp;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All-ones kernel and image: every window sums to 9.
        fill_ones();
        push4(8'd9, 8'd9, 8'd9, 8'd9);
        send_frame(1'b0);
        @(negedge clk);
        chk("busy_after_load", busy, 1);
        chk("in_ready_computing", in_ready, 0);
        wait_drain();
        post_frame();

        // Centre tap over a ramp, with back-pressure on result 2.
        fill_center_ramp();
        push4(8'd5, 8'd6, 8'd9, 8'd10);
        base = n_acc;
        send_frame(1'b0);
        wait_acc(base + 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 6);
            chk("stall_last", out_last, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
        post_frame();

        // Full-scale operands: 585225 truncates to 9, saturates to 255.
`ifdef CONV_SAT_EN
        sat_exp = 8'd255;
`else
        sat_exp = 8'd9;
`endif
        for (int i = 0; i < 9; i++) ker_v[i] = 8'd255;
        for (int i = 0; i < 16; i++) pix_v[i] = 8'd255;
        push4(sat_exp, sat_exp, sat_exp, sat_exp);
        send_frame(1'b0);
        wait_drain();
        post_frame();

        // Same ramp frame with in_valid toggling every cycle.
        fill_center_ramp();
        push4(8'd5, 8'd6, 8'd9, 8'd10);
        send_frame(1'b1);
        wait_drain();
        post_frame();

        // Reset while result 3 is being computed.
        fill_center_ramp();
        push4(8'd5, 8'd6, 8'd9, 8'd10);
        base = n_acc;
        send_frame(1'b0);
        wait_acc(base + 2);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_data", out_data, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        fill_ones();
        push4(8'd9, 8'd9, 8'd9, 8'd9);
        send_frame(1'b0);
        wait_drain();
        post_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
